// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch/retire sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_ISSUE    = 3'd2,
    S_EXEC     = 3'd3,
    S_HALTED   = 3'd4
  } seq_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
  localparam logic [31:0] PC_STEP        = 32'd4;

  // Instruction targets must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/issue/retire controller owning the architectural PC.
// The next-PC ALU lives beside this block; its result arrives on next_pc with retire.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  output logic [31:0] pc,
  input  logic        retire,
  input  logic [31:0] next_pc,
  input  logic        halt,
  input  logic        exc,
  output logic [31:0] epc,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  seq_state_e  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_epc;
  logic [31:0] r_cnt;
  logic        r_imem_req;
  logic        r_inst_valid;
  logic        r_halted;

  logic        w_misaligned;
  logic [31:0] w_pc_inc;
  logic [31:0] w_cnt_inc;

  assign w_misaligned = is_misaligned(next_pc);
  assign w_pc_inc     = r_pc + PC_STEP;
  assign w_cnt_inc    = r_cnt + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_epc        <= '0;
      r_cnt        <= '0;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_imem_req <= 1'b1;
          r_state    <= S_WAIT_ACK;
        end
        // Request and address stay put until memory answers; exc waits for ISSUE/EXEC.
        S_WAIT_ACK: begin
          if (imem_ack) begin
            r_inst       <= imem_data;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (exc) begin
            r_inst_valid <= 1'b0;
            r_epc        <= r_pc;
            r_pc         <= EXC_VECTOR;
            r_state      <= S_FETCH;
          end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exc) begin
            r_epc   <= r_pc;
            r_pc    <= EXC_VECTOR;
            r_state <= S_FETCH;
          end else if (retire && halt) begin
            r_cnt    <= w_cnt_inc;
            r_pc     <= w_pc_inc;
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else if (retire && w_misaligned) begin
            // Bad target still counts as retired, then traps like an exception.
            r_cnt   <= w_cnt_inc;
            r_epc   <= r_pc;
            r_pc    <= EXC_VECTOR;
            r_state <= S_FETCH;
          end else if (retire) begin
            r_cnt   <= w_cnt_inc;
            r_pc    <= next_pc;
            r_state <= S_FETCH;
          end
        end
        S_HALTED: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign inst_valid  = r_inst_valid;
  assign inst        = r_inst;
  assign pc          = r_pc;
  assign epc         = r_epc;
  assign halted      = r_halted;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expectations per step.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] next_pc;
  logic        halt;
  logic        exc;
  logic [31:0] epc;
  logic        halted;
  logic [31:0] retired_cnt;

  int n_chk;
  int n_fail;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .pc         (pc),
    .retire     (retire),
    .next_pc    (next_pc),
    .halt       (halt),
    .exc        (exc),
    .epc        (epc),
    .halted     (halted),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait ack/ready/retire starting from WAIT_ACK; ends just after the retire edge.
  task automatic do_insn(input logic [31:0] data, input logic [31:0] nxt,
                         input logic hlt, input logic ex);
    imem_ack = 1'b1; imem_data = data;
    step();
    imem_ack = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    retire = 1'b1; next_pc = nxt; halt = hlt; exc = ex;
    step();
    retire = 1'b0; halt = 1'b0; exc = 1'b0;
  endtask

  initial begin
    int  n;
    logic saw_req;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; inst_ready = 1'b0;
    retire = 1'b0; next_pc = '0; halt = 1'b0; exc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cnt", retired_cnt, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    rst_n = 1'b1;

    // First fetch with two ack wait cycles
    step();
    chk("f1_req", {31'b0, imem_req}, 32'h1);
    chk("f1_addr", imem_addr, 32'h0);
    step(); step();
    chk("f1_req_held", {31'b0, imem_req}, 32'h1);
    imem_ack = 1'b1; imem_data = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    chk("f1_inst", inst, 32'h2008_0005);
    chk("f1_valid", {31'b0, inst_valid}, 32'h1);
    chk("f1_req_drop", {31'b0, imem_req}, 32'h0);
    retire = 1'b1; next_pc = 32'h100;
    step();
    retire = 1'b0;
    chk("issue_hold", {31'b0, inst_valid}, 32'h1);
    chk("issue_ret_ign", retired_cnt, 32'h0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("f1_valid_drop", {31'b0, inst_valid}, 32'h0);
    retire = 1'b1; next_pc = 32'h4;
    step();
    retire = 1'b0;
    chk("f1_pc", pc, 32'h4);
    chk("f1_cnt", retired_cnt, 32'h1);
    chk("f1_req_low", {31'b0, imem_req}, 32'h0);
    step();
    chk("f2_req", {31'b0, imem_req}, 32'h1);
    chk("f2_addr", imem_addr, 32'h4);

    // Taken branch, zero-wait period
    do_insn(32'h1111_0000, 32'h40, 1'b0, 1'b0);
    n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    chk("br_period", 32'(3 + n), 32'd4);
    chk("br_addr", imem_addr, 32'h40);
    chk("br_cnt", retired_cnt, 32'h2);

    exc = 1'b1;
    step();
    exc = 1'b0;
    chk("wait_exc_req", {31'b0, imem_req}, 32'h1);
    chk("wait_exc_pc", pc, 32'h40);

    // Misaligned target at pc=8
    do_insn(32'h0, 32'h8, 1'b0, 1'b0);
    step();
    do_insn(32'h0, 32'h42, 1'b0, 1'b0);
    chk("mis_epc", epc, 32'h8);
    chk("mis_pc", pc, 32'h80);
    chk("mis_cnt", retired_cnt, 32'h4);
    step();

    // Exception while offering to decode drops the instruction
    imem_ack = 1'b1; imem_data = 32'hABCD_0001;
    step();
    imem_ack = 1'b0;
    exc = 1'b1;
    step();
    exc = 1'b0;
    chk("iss_exc_valid", {31'b0, inst_valid}, 32'h0);
    chk("iss_exc_epc", epc, 32'h80);
    chk("iss_exc_cnt", retired_cnt, 32'h4);
    step();
    chk("iss_exc_refetch", {31'b0, imem_req}, 32'h1);

    // exc beats retire in EXEC at pc=0x10
    do_insn(32'h0, 32'h10, 1'b0, 1'b0);
    step();
    do_insn(32'h0, 32'h14, 1'b0, 1'b1);
    chk("exr_epc", epc, 32'h10);
    chk("exr_pc", pc, 32'h80);
    chk("exr_cnt", retired_cnt, 32'h5);
    step();

    // Halt at pc=0x20
    do_insn(32'h0, 32'h20, 1'b0, 1'b0);
    step();
    do_insn(32'h0, 32'h99, 1'b1, 1'b0);
    chk("hlt_halted", {31'b0, halted}, 32'h1);
    chk("hlt_pc", pc, 32'h24);
    chk("hlt_cnt", retired_cnt, 32'h7);
    saw_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exc = i[0];
      step();
      if (imem_req) saw_req = 1'b1;
    end
    exc = 1'b0;
    chk("hlt_no_req", {31'b0, saw_req}, 32'h0);
    chk("hlt_stays", {31'b0, halted}, 32'h1);
    chk("hlt_pc_stays", pc, 32'h24);

    // PC wrap on halt at 0xFFFF_FFFC
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", {31'b0, halted}, 32'h0);
    rst_n = 1'b1;
    step();
    do_insn(32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    do_insn(32'h0, 32'h0, 1'b1, 1'b0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_cnt", retired_cnt, 32'h2);

    // Reset in the middle of a fetch handshake
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    do_insn(32'h0, 32'h30, 1'b0, 1'b0);
    step();
    chk("mid_req_before", {31'b0, imem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_req_async", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_pc", pc, 32'h0);
    chk("mid_cnt", retired_cnt, 32'h0);
    step();
    chk("mid_refetch", {31'b0, imem_req}, 32'h1);
    chk("mid_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
